// File: rtl/multi_channel_event_counter.sv
// Multi-channel edge counter with per-channel compare/auto-reload, overflow
// detection and a level IRQ, exposed as an Avalon-MM slave with read latency 1.
module multi_channel_event_counter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(NUM_CH)+1:0]   avs_address,
  input  logic                        avs_read,
  input  logic                        avs_write,
  input  logic [31:0]                 avs_writedata,
  output logic [31:0]                 avs_readdata,
  input  logic [NUM_CH-1:0]           counter_in,
  output logic                        irq
);

  localparam int unsigned CTRL_W = 5;
  localparam logic [1:0] REG_COUNT   = 2'd0;
  localparam logic [1:0] REG_COMPARE = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
  logic [NUM_CH-1:0]      hist_q, hist_d;
  logic [NUM_CH-1:0]      rise_q, rise_d;
  logic [NUM_CH-1:0]      fall_q, fall_d;
  logic [CNT_W-1:0]       cnt_q  [NUM_CH];
  logic [CNT_W-1:0]       cnt_d  [NUM_CH];
  logic [CNT_W-1:0]       cmp_q  [NUM_CH];
  logic [CNT_W-1:0]       cmp_d  [NUM_CH];
  logic [CTRL_W-1:0]      ctrl_q [NUM_CH];
  logic [CTRL_W-1:0]      ctrl_d [NUM_CH];
  logic [1:0]             sts_q  [NUM_CH];
  logic [1:0]             sts_d  [NUM_CH];
  logic [31:0]            rdata_q, rdata_d;
  logic                   irq_q, irq_d;

  logic [31:0]            addr_ch_c;
  logic [1:0]             addr_reg_c;
  logic [CNT_W-1:0]       inc_c  [NUM_CH];
  logic [NUM_CH-1:0]      evt_c, hit_c, cnt_wr_c, match_c, ovf_c;
  logic [1:0]             set_c  [NUM_CH];
  logic [1:0]             w1c_c  [NUM_CH];
  logic                   unused_wdata;

  assign addr_ch_c    = 32'(avs_address >> 2);
  assign addr_reg_c   = avs_address[1:0];
  assign unused_wdata = ^avs_writedata;

  // Input pipeline, per-channel counter/status update, register reads and IRQ
  always_comb begin
    rdata_d = avs_read ? 32'd0 : rdata_q;
    irq_d   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], counter_in[i]};
      hist_d[i] = sync_q[i][SYNC_STAGES-1];
      rise_d[i] = sync_q[i][SYNC_STAGES-1] & ~hist_q[i];
      fall_d[i] = ~sync_q[i][SYNC_STAGES-1] & hist_q[i];
      cnt_d[i]  = cnt_q[i];
      cmp_d[i]  = cmp_q[i];
      ctrl_d[i] = ctrl_q[i];

      hit_c[i]    = (addr_ch_c == 32'(i));
      cnt_wr_c[i] = avs_write && hit_c[i] && (addr_reg_c == REG_COUNT);
      evt_c[i]    = ctrl_q[i][0] && (ctrl_q[i][1] ? fall_q[i] : rise_q[i]);
      inc_c[i]    = cnt_q[i] + CNT_W'(1);
      match_c[i]  = evt_c[i] && (cmp_q[i] != '0) && (inc_c[i] == cmp_q[i]);
      ovf_c[i]    = evt_c[i] && (cnt_q[i] == '1);

      // A software COUNT clear discards any event landing in the same cycle
      set_c[i] = cnt_wr_c[i] ? 2'b00 : {ovf_c[i], match_c[i]};
      if (cnt_wr_c[i]) begin
        cnt_d[i] = '0;
      end else if (evt_c[i]) begin
        cnt_d[i] = (match_c[i] && ctrl_q[i][4]) ? '0 : inc_c[i];
      end

      if (avs_write && hit_c[i] && (addr_reg_c == REG_COMPARE)) begin
        cmp_d[i] = avs_writedata[CNT_W-1:0];
      end
      if (avs_write && hit_c[i] && (addr_reg_c == REG_CTRL)) begin
        ctrl_d[i] = avs_writedata[CTRL_W-1:0];
      end
      w1c_c[i] = (avs_write && hit_c[i] && (addr_reg_c == REG_STATUS)) ?
                 avs_writedata[1:0] : 2'b00;
      sts_d[i] = (sts_q[i] & ~w1c_c[i]) | set_c[i];

      irq_d = irq_d | (|(sts_q[i] & {ctrl_q[i][3], ctrl_q[i][2]}));

      if (avs_read && hit_c[i]) begin
        case (addr_reg_c)
          REG_COUNT:   rdata_d = 32'(cnt_q[i]);
          REG_COMPARE: rdata_d = 32'(cmp_q[i]);
          REG_CTRL:    rdata_d = 32'(ctrl_q[i]);
          default:     rdata_d = 32'(sts_q[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
        cmp_q[i]  <= '0;
        ctrl_q[i] <= '0;
        sts_q[i]  <= '0;
      end
      hist_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
        cmp_q[i]  <= cmp_d[i];
        ctrl_q[i] <= ctrl_d[i];
        sts_q[i]  <= sts_d[i];
      end
      hist_q  <= hist_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_multi_channel_event_counter.sv
// Scoreboard bench for multi_channel_event_counter: random and directed pulses
// checked against a per-channel register model.
module tb_multi_channel_event_counter;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SS     = 2;
  localparam int unsigned AW     = $clog2(NUM_CH) + 2;
  localparam int unsigned MAXV   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [AW-1:0]     avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic [NUM_CH-1:0] counter_in;
  logic              irq;

  multi_channel_event_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .counter_in(counter_in), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int m_cnt [NUM_CH];
  int m_cmp [NUM_CH];
  int m_ctrl[NUM_CH];
  int m_sts [NUM_CH];

  function automatic void m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_cmp[c] = 0; m_ctrl[c] = 0; m_sts[c] = 0;
    end
  endfunction

  // One counted event on a channel, from the register-level rules
  function automatic void m_event(input int ch);
    int nxt;
    if ((m_ctrl[ch] & 1) == 0) return;
    nxt = (m_cnt[ch] + 1) % (MAXV + 1);
    if (m_cnt[ch] == int'(MAXV)) m_sts[ch] = m_sts[ch] | 2;
    if (m_cmp[ch] != 0 && nxt == m_cmp[ch]) begin
      m_sts[ch] = m_sts[ch] | 1;
      if ((m_ctrl[ch] & 16) != 0) nxt = 0;
    end
    m_cnt[ch] = nxt;
  endfunction

  function automatic void m_write(input int a, input logic [31:0] d);
    int ch;
    ch = a / 4;
    case (a % 4)
      0: m_cnt[ch] = 0;
      1: m_cmp[ch] = int'(d & 32'(MAXV));
      2: m_ctrl[ch] = int'(d & 32'd31);
      default: m_sts[ch] = m_sts[ch] & ~int'(d & 32'd3);
    endcase
  endfunction

  function automatic logic [31:0] m_read(input int a);
    int ch;
    ch = a / 4;
    case (a % 4)
      0: return 32'(m_cnt[ch]);
      1: return 32'(m_cmp[ch]);
      2: return 32'(m_ctrl[ch]);
      default: return 32'(m_sts[ch]);
    endcase
  endfunction

  function automatic logic m_irq();
    for (int c = 0; c < NUM_CH; c++) begin
      if ((m_sts[c] & 1) != 0 && (m_ctrl[c] & 4) != 0) return 1'b1;
      if ((m_sts[c] & 2) != 0 && (m_ctrl[c] & 8) != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", nm, got, exp);
    end
  endfunction

  // Monitor: compares readdata the cycle after every sampled read
  logic rd_flag;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_flag <= 1'b0;
    else          rd_flag <= avs_read;
  end

  always @(negedge clk) begin
    if (rd_flag) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got=0x%08h exp=none", avs_readdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (avs_readdata !== mon_e.val) begin
          errors++;
          $display("FAIL %s got=0x%08h exp=0x%08h", mon_e.name, avs_readdata, mon_e.val);
        end
      end
    end
  end

  task automatic bus_read(input int a, input string nm);
    exp_t e;
    e.name = $sformatf("%s_a%0d", nm, a);
    e.val  = m_read(a);
    avs_address = AW'(a);
    avs_read = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    avs_address = AW'(a);
    avs_writedata = d;
    avs_write = 1'b1;
    m_write(a, d);
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic read_all(input string nm);
    for (int a = 0; a < 4 * int'(NUM_CH); a++) bus_read(a, nm);
  endtask

  task automatic check_irq(input string nm);
    @(negedge clk);
    check(nm, 32'(irq), 32'(m_irq()));
  endtask

  // Full pulse (4 clk high) then enough low time for either edge to land
  task automatic pulse(input logic [NUM_CH-1:0] mask);
    counter_in = counter_in | mask;
    repeat (4) @(negedge clk);
    counter_in = counter_in & ~mask;
    repeat (6) @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) if (mask[c]) m_event(c);
  endtask

  // Rising edge on ch whose count cycle coincides with a bus write
  task automatic collide(input int ch, input int a, input logic [31:0] d);
    counter_in[ch] = 1'b1;
    repeat (3) @(negedge clk);
    avs_address = AW'(a);
    avs_writedata = d;
    avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    counter_in[ch] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; counter_in = '0;
    m_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    read_all("rst");

    // ch0 rising, falling, disabled
    bus_write(2, 32'h1);
    repeat (5) pulse(NUM_CH'(1));
    bus_read(0, "rise5");
    bus_write(0, 32'h0);
    bus_write(2, 32'h3);
    repeat (5) pulse(NUM_CH'(1));
    bus_read(0, "fall5");
    bus_write(2, 32'h0);
    repeat (3) pulse(NUM_CH'(1));
    bus_read(0, "disabled");

    // ch1 match with auto-reload, IRQ lags status by one cycle
    bus_write(5, 32'd3);
    bus_write(6, 32'h15);
    pulse(NUM_CH'(2));
    pulse(NUM_CH'(2));
    counter_in[1] = 1'b1;
    repeat (4) @(negedge clk);
    check("match_irq_lag", 32'(irq), 32'd0);
    m_event(1);
    @(negedge clk);
    check("match_irq_set", 32'(irq), 32'd1);
    counter_in[1] = 1'b0;
    repeat (6) @(negedge clk);
    bus_read(4, "reload_cnt");
    bus_read(7, "match_sts");
    bus_write(7, 32'h1);
    check_irq("match_irq_clr");
    bus_read(7, "match_sts_clr");

    // Simultaneous COUNT write and edge; W1C and match together
    bus_write(2, 32'h1);
    pulse(NUM_CH'(1));
    collide(0, 0, 32'h0);
    m_cnt[0] = 0;
    bus_read(0, "cnt_wr_wins");
    pulse(NUM_CH'(2));
    pulse(NUM_CH'(2));
    collide(1, 7, 32'h1);
    m_event(1);
    bus_read(7, "set_beats_w1c");
    bus_read(4, "set_beats_w1c_cnt");
    check_irq("set_beats_w1c_irq");
    bus_write(7, 32'h1);
    check_irq("w1c_irq_clr");

    // ch2 wrap at 8 bits
    bus_write(10, 32'h9);
    repeat (MAXV) pulse(NUM_CH'(4));
    bus_read(8, "cnt_max");
    pulse(NUM_CH'(4));
    bus_read(8, "wrap_cnt");
    bus_read(11, "wrap_sts");
    check_irq("wrap_irq");
    check("wrap_irq_hi", 32'(irq), 32'd1);
    bus_write(11, 32'h2);
    check_irq("wrap_irq_clr");

    // All channels in the same clock; latency sampled every cycle on ch3
    for (int c = 0; c < int'(NUM_CH); c++) bus_write(c * 4 + 2, 32'h1);
    counter_in = '1;
    for (int k = 0; k <= int'(SS) + 2; k++) begin
      if (k == int'(SS) + 2) for (int c = 0; c < int'(NUM_CH); c++) m_event(c);
      bus_read(12, $sformatf("latency_k%0d", k));
    end
    counter_in = '0;
    repeat (6) @(negedge clk);
    for (int c = 0; c < int'(NUM_CH); c++) bus_read(c * 4, "all_ch");

    // Randomised configuration and traffic
    for (int c = 0; c < int'(NUM_CH); c++) begin
      bus_write(c * 4 + 1, 32'($urandom_range(0, 6)));
      bus_write(c * 4 + 2, 32'($urandom_range(0, 31)));
    end
    for (int it = 0; it < 40; it++) begin
      pulse(NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1)));
      case ($urandom_range(0, 5))
        0: bus_read(int'($urandom_range(0, 4 * NUM_CH - 1)), "rnd");
        1: bus_write(int'($urandom_range(0, NUM_CH - 1)) * 4 + 3, 32'($urandom_range(0, 3)));
        2: bus_write(int'($urandom_range(0, NUM_CH - 1)) * 4, 32'h0);
        default: ;
      endcase
    end
    read_all("rnd_end");
    check_irq("rnd_irq");

    // Reset in the middle of an edge in flight
    bus_write(2, 32'h1);
    pulse(NUM_CH'(1));
    pulse(NUM_CH'(1));
    counter_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 counter_in = '0;
    m_reset();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("rst2_readdata", avs_readdata, 32'd0);
    check("rst2_irq", 32'(irq), 32'd0);
    read_all("rst2");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL read_drain got=%0d exp=0 outstanding", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
